// File: rtl/pulse_sched_pkg.sv
// Shared types and parameter defaults for the pulse scheduler.
package pulse_sched_pkg;

  localparam int N_DEF  = 4;
  localparam int LW_DEF = 8;
  localparam int GW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after (last + 1) mod N, wrapping around.
module rr_pick
  import pulse_sched_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          valid,
  output logic [SW-1:0] idx
);

  // Walk offsets 1..N from the last grant; the first hit wins.
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shared pulse stretcher: arbitrates per-requester event strobes round-robin
// and emits one len-clock pulse per request with a gap-clock low guard time.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF,
  parameter int GW = GW_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic          c,
  input  logic          r,
  input  logic [N-1:0]  n,
  input  logic [LW-1:0] len,
  input  logic [GW-1:0] gap,
  input  logic          clr,
  output logic          w,
  output logic [SW-1:0] sel,
  output logic          busy,
  output logic [N-1:0]  ovf
);

  state_t        state, state_nx;
  logic [N-1:0]  pend, pend_nx;
  logic [N-1:0]  ovf_nx;
  logic [N-1:0]  gmask;
  logic [SW-1:0] last, last_nx;
  logic [SW-1:0] sel_nx;
  logic [LW-1:0] cnt, cnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic [LW-1:0] len_ld;
  logic          w_nx;
  logic          grant;
  logic          pick_vld;
  logic [SW-1:0] pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req   (pend),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Counter holds remaining clocks minus one, so len=0 behaves like len=1.
  assign len_ld = (len == '0) ? '0 : len - LW'(1);
  assign busy   = (state != S_IDLE);

  // Next-state, grant decision, pending and overflow bookkeeping.
  always_comb begin
    state_nx = state;
    w_nx     = w;
    sel_nx   = sel;
    last_nx  = last;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    grant    = 1'b0;
    gmask    = '0;

    case (state)
      S_IDLE: begin
        if (pick_vld) grant = 1'b1;
      end
      S_PULSE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - LW'(1);
        end else if (gap != '0) begin
          state_nx = S_GAP;
          gcnt_nx  = gap - GW'(1);
          w_nx     = 1'b0;
        end else if (pick_vld) begin
          grant = 1'b1;
        end else begin
          state_nx = S_IDLE;
          w_nx     = 1'b0;
        end
      end
      S_GAP: begin
        if (gcnt != '0) begin
          gcnt_nx = gcnt - GW'(1);
        end else if (pick_vld) begin
          grant = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        w_nx     = 1'b0;
      end
    endcase

    // A grant from any state starts a fresh pulse on this edge.
    if (grant) begin
      state_nx        = S_PULSE;
      w_nx            = 1'b1;
      sel_nx          = pick_idx;
      last_nx         = pick_idx;
      cnt_nx          = len_ld;
      gmask[pick_idx] = 1'b1;
    end

    // A strobe on the granting edge re-arms that requester without overflow.
    pend_nx = (pend & ~gmask) | n;
    ovf_nx  = (clr ? '0 : ovf) | (n & pend & ~gmask);
  end

  // State and registered outputs; reset discards everything in flight.
  always_ff @(posedge c) begin
    if (r) begin
      state <= S_IDLE;
      w     <= 1'b0;
      sel   <= '0;
      last  <= SW'(N - 1);
      pend  <= '0;
      ovf   <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      w     <= w_nx;
      sel   <= sel_nx;
      last  <= last_nx;
      pend  <= pend_nx;
      ovf   <= ovf_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

endmodule

// File: doc/pulse_sched.md
PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 Parameter N, default 4: number of requesters; legal values 2..8.
REQ-002 Parameter LW, default 8: width of the pulse-length field.
REQ-003 Parameter GW, default 4: width of the guard-gap field.
REQ-004 Port c, input, 1: single clock; all logic rising-edge.
REQ-005 Port r, input, 1: synchronous, active-high reset.
REQ-006 Port n, input, N: per-requester event strobes, each nominally 1 clock wide.
REQ-007 Port len, input, LW: output pulse width in clocks.
REQ-008 Port gap, input, GW: minimum low time in clocks between consecutive pulses.
REQ-009 Port clr, input, 1: clears all overflow flags.
REQ-010 Port w, output, 1: shared stretched-pulse output, registered.
REQ-011 Port sel, output, clog2(N): index of the requester owning the current or most recent pulse, registered.
REQ-012 Port busy, output, 1: high in PULSE or GAP.
REQ-013 Port ovf, output, N: sticky per-requester overflow flags.

Function
REQ-014 A pending bit per requester shall be set on any edge where n[i]=1.
REQ-015 FSM states shall be IDLE, PULSE and GAP.
REQ-016 In IDLE with any pending bit set, the next edge shall enter PULSE, set w=1, load sel with the granted index, and clear that pending bit.
REQ-017 Grant shall be round-robin: search starts at index (last grant + 1) mod N; after reset the last grant is N-1, so index 0 has top priority.
REQ-018 Latency: an n[i] strobe at edge k into an idle block with no other pending requests shall give w=1 after edge k+1.
REQ-019 len shall be sampled at grant; w shall stay high for exactly len clocks, and len=0 shall be treated as 1; changes to len mid-pulse shall be ignored.
REQ-020 At the end of PULSE, w shall drop; the FSM shall enter GAP for gap clocks (sampled at the end of PULSE), or skip GAP when gap=0.
REQ-021 Leaving GAP, or leaving PULSE with gap=0, the FSM shall grant the next pending requester on the same edge; otherwise it shall return to IDLE.
REQ-022 A back-to-back grant with gap=0 shall hold w high continuously and update sel on the boundary edge.
REQ-023 n[i]=1 while pending[i] is already set and not being cleared on that edge shall set ovf[i]; the request shall be merged, not queued twice.
REQ-024 n[i]=1 on the same edge that grants i shall leave pending[i] set, with no overflow.
REQ-025 clr shall zero ovf; a coincident overflow event shall win, leaving that bit set.
REQ-026 Strobes held high for several clocks shall count as one request plus overflow on each further cycle.

Reset
REQ-027 While r=1: state=IDLE, w=0, busy=0, sel=0, pending=0, ovf=0, counters=0, last grant=N-1.
REQ-028 Reset asserted mid-pulse or mid-gap shall force w=0 on the following edge and discard all pending requests; n is ignored during reset.

Structure
REQ-029 Package pulse_sched_pkg shall hold the state enumeration and the N/LW/GW defaults.
REQ-030 Round-robin selection shall be the combinational sub-module rr_pick (inputs: request vector and last grant; outputs: valid and index).
REQ-031 Length and gap counters shall be down-counters; the implementation shall not use a delay line.

Verification
REQ-032 After reset, len=32, gap=0, n[2] pulsed once -> w high for exactly 32 clocks, starting 2 edges after the strobe; sel=2; busy deasserts with w.
REQ-033 len=4, gap=3, n=4'b1111 for one clock -> four pulses in order sel=0,1,2,3, each 4 high with 3 low between them; ovf=0.
REQ-034 len=5, gap=0, n[0] and n[1] together -> w high for 10 continuous clocks; sel changes 0->1 after 5.
REQ-035 During a pulse for requester 1, strobe n[3] twice -> ovf[3]=1 and only one pulse for requester 3; clr then gives ovf=0.
REQ-036 len=0 -> 1-clock pulse; changing len from 8 to 2 mid-pulse -> the pulse still lasts 8 clocks.
REQ-037 r asserted at clock 3 of a 20-clock pulse while requests are pending -> w=0 next edge and no further pulses after r drops until a new strobe.
